// File: rtl/cpu_bus_port_arb_pkg.sv
// Shared types for the CPU bus port arbiter: bus widths, state/owner encodings
// and the round-robin winner selection used in IDLE.
package cpu_bus_port_arb_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int TO_CNT_W    = 8;

  typedef enum logic [1:0] {
    BPA_IDLE      = 2'd0,
    BPA_WAIT_GRNT = 2'd1,
    BPA_OWN       = 2'd2
  } bpa_state_e;

  typedef enum logic {
    BPA_OWNER_IF  = 1'b0,
    BPA_OWNER_MEM = 1'b1
  } bpa_owner_e;

  // On a tie the requester that did not own the bus last time wins.
  function automatic bpa_owner_e pick_owner(input logic if_req_n,
                                            input logic mem_req_n,
                                            input bpa_owner_e last_owner);
    bpa_owner_e win;
    if (!if_req_n && !mem_req_n) begin
      if (last_owner == BPA_OWNER_IF) win = BPA_OWNER_MEM;
      else                            win = BPA_OWNER_IF;
    end else if (!if_req_n) begin
      win = BPA_OWNER_IF;
    end else begin
      win = BPA_OWNER_MEM;
    end
    return win;
  endfunction

endpackage

// File: rtl/cpu_bus_port_arb_timeout_cnt.sv
// Slave-response watchdog: counts strobed cycles without ready and flags the
// cycle on which the transfer must be aborted.
module bus_timeout_cnt
  import cpu_bus_port_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam bit                  ENABLE_C = (TIMEOUT_CYC != 0);
  localparam logic [TO_CNT_W-1:0] LIMIT_C  =
    (TIMEOUT_CYC == 0) ? 8'd0 : 8'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0] cnt_r;

  assign expire = ENABLE_C && run && (cnt_r == LIMIT_C);

  // Wait counter; restarts whenever the slave answers, the strobe drops or the bus is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 8'd0;
    end else if (clr || !run || expire) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_bus_port_arb.sv
// Merges the IF and MEM stage bus requesters onto one external master port
// with round-robin arbitration, zero-latency pass-through and a slave watchdog.
module cpu_bus_port_arb
  import cpu_bus_port_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_req_,
  input  logic [WORD_ADDR_W-1:0] if_addr,
  input  logic                   if_as_,
  input  logic                   if_rw,
  input  logic [WORD_DATA_W-1:0] if_wr_data,
  output logic                   if_grnt_,
  output logic                   if_rdy_,
  output logic [WORD_DATA_W-1:0] if_rd_data,
  output logic                   if_err,
  input  logic                   mem_req_,
  input  logic [WORD_ADDR_W-1:0] mem_addr,
  input  logic                   mem_as_,
  input  logic                   mem_rw,
  input  logic [WORD_DATA_W-1:0] mem_wr_data,
  output logic                   mem_grnt_,
  output logic                   mem_rdy_,
  output logic [WORD_DATA_W-1:0] mem_rd_data,
  output logic                   mem_err,
  output logic                   m_req_,
  output logic [WORD_ADDR_W-1:0] m_addr,
  output logic                   m_as_,
  output logic                   m_rw,
  output logic [WORD_DATA_W-1:0] m_wr_data,
  input  logic                   m_grnt_,
  input  logic                   m_rdy_,
  input  logic [WORD_DATA_W-1:0] m_rd_data
);

  bpa_state_e state_r, state_nxt_s;
  bpa_owner_e owner_r, owner_nxt_s;
  bpa_owner_e last_owner_r, last_owner_nxt_s;

  logic                   own_is_mem_s;
  logic                   own_req_s;
  logic                   own_as_s;
  logic                   own_rw_s;
  logic [WORD_ADDR_W-1:0] own_addr_s;
  logic [WORD_DATA_W-1:0] own_wr_data_s;
  logic                   run_s;
  logic                   rel_s;
  logic                   expire_s;

  assign own_is_mem_s  = (owner_r == BPA_OWNER_MEM);
  assign own_req_s     = own_is_mem_s ? mem_req_    : if_req_;
  assign own_as_s      = own_is_mem_s ? mem_as_     : if_as_;
  assign own_rw_s      = own_is_mem_s ? mem_rw      : if_rw;
  assign own_addr_s    = own_is_mem_s ? mem_addr    : if_addr;
  assign own_wr_data_s = own_is_mem_s ? mem_wr_data : if_wr_data;

  // A preempted owner does not drive a strobe, so it must not age the watchdog.
  assign run_s = (state_r == BPA_OWN) && !own_as_s && !m_grnt_ && m_rdy_;
  assign rel_s = (state_r == BPA_OWN) && own_req_s;

  bus_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .run    (run_s),
    .clr    (rel_s),
    .expire (expire_s)
  );

  // Arbitration state, current owner and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= BPA_IDLE;
      owner_r      <= BPA_OWNER_IF;
      last_owner_r <= BPA_OWNER_IF;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      last_owner_r <= last_owner_nxt_s;
    end
  end

  // Next-state decode plus the combinational bus steering for the current owner.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    last_owner_nxt_s = last_owner_r;
    m_req_           = 1'b1;
    m_as_            = 1'b1;
    m_rw             = 1'b1;
    m_addr           = '0;
    m_wr_data        = '0;
    if_grnt_         = 1'b1;
    if_rdy_          = 1'b1;
    if_rd_data       = '0;
    if_err           = 1'b0;
    mem_grnt_        = 1'b1;
    mem_rdy_         = 1'b1;
    mem_rd_data      = '0;
    mem_err          = 1'b0;

    case (state_r)
      BPA_IDLE: begin
        if (!if_req_ || !mem_req_) begin
          owner_nxt_s = pick_owner(if_req_, mem_req_, last_owner_r);
          state_nxt_s = BPA_WAIT_GRNT;
        end else begin
          state_nxt_s = BPA_IDLE;
        end
      end
      BPA_WAIT_GRNT: begin
        m_req_ = 1'b0;
        if (own_req_s) begin
          state_nxt_s = BPA_IDLE;
        end else if (!m_grnt_) begin
          state_nxt_s = BPA_OWN;
        end else begin
          state_nxt_s = BPA_WAIT_GRNT;
        end
      end
      BPA_OWN: begin
        m_req_    = 1'b0;
        m_as_     = own_as_s | m_grnt_ | expire_s;
        m_rw      = own_rw_s;
        m_addr    = own_addr_s;
        m_wr_data = own_wr_data_s;
        if (own_is_mem_s) begin
          mem_grnt_   = 1'b0;
          mem_rdy_    = m_rdy_ & ~expire_s;
          mem_rd_data = expire_s ? '0 : m_rd_data;
          mem_err     = expire_s;
        end else begin
          if_grnt_    = 1'b0;
          if_rdy_     = m_rdy_ & ~expire_s;
          if_rd_data  = expire_s ? '0 : m_rd_data;
          if_err      = expire_s;
        end
        if (own_req_s) begin
          state_nxt_s      = BPA_IDLE;
          last_owner_nxt_s = owner_r;
        end else if (m_grnt_) begin
          state_nxt_s = BPA_WAIT_GRNT;
        end else begin
          state_nxt_s = BPA_OWN;
        end
      end
      default: begin
        state_nxt_s = BPA_IDLE;
      end
    endcase
  end

endmodule
